ex_muldiv_unit: RTL and testbench

//  Execute-stage iterative RV32M multiply/divide unit. Consumes the ID/EX barrier's ex* operands and

---
 rtl/ex_muldiv_unit.sv | 103 ++++++++++
 tb/tb_ex_muldiv_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide for the execute stage, stalling the front end while busy.
// Define MULDIV_EARLY_OUT_EN to finish trivial multiplies/divides in a single cycle.
module ex_muldiv_unit #(
    parameter logic [2:0] MULDIV_ALUOP  = 3'b010,
    parameter logic [6:0] MULDIV_FUNCT7 = 7'b0000001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  exAluOp,
    input  logic [2:0]  exFunct3,
    input  logic [6:0]  exFunct7,
    input  logic [31:0] exLHSOperand,
    input  logic [31:0] exRHSOperand,
    output logic        mdStall,
    output logic [31:0] mdResult,
    output logic        mdResultValid
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [2:0]  r_f3;
    logic [31:0] r_op;
    logic [63:0] r_acc;
    logic        r_negq, r_negr;
    logic        w_start, w_div, w_sa, w_sb, w_na, w_nb, w_dz, w_ovf, w_early, w_ge;
    logic [31:0] w_ma, w_mb, w_fast_res, w_early_res, w_rsub, w_q, w_r, w_final;
    logic [32:0] w_msum, w_rem;
    logic [63:0] w_next, w_prod;
    assign w_start = exAluOp == MULDIV_ALUOP && exFunct7 == MULDIV_FUNCT7;
    assign w_div   = exFunct3[2];
    assign w_sa    = exFunct3[2] ? !exFunct3[0] : exFunct3[1:0] != 2'b11;
    assign w_sb    = exFunct3[2] ? !exFunct3[0] : !exFunct3[1];
    assign w_na    = w_sa && exLHSOperand[31];
    assign w_nb    = w_sb && exRHSOperand[31];
    assign w_ma    = w_na ? -exLHSOperand : exLHSOperand;
    assign w_mb    = w_nb ? -exRHSOperand : exRHSOperand;
    assign w_dz    = w_div && exRHSOperand == 32'd0;
    assign w_ovf   = w_div && !exFunct3[0] && exLHSOperand == 32'h8000_0000 && exRHSOperand == 32'hFFFF_FFFF;
    assign w_fast_res = w_dz ? (exFunct3[1] ? exLHSOperand : 32'hFFFF_FFFF) : (exFunct3[1] ? 32'd0 : 32'h8000_0000);
`ifdef MULDIV_EARLY_OUT_EN
    assign w_early     = w_div ? w_ma < w_mb : (exLHSOperand == 32'd0 || exRHSOperand == 32'd0);
    assign w_early_res = (w_div && exFunct3[1]) ? exLHSOperand : 32'd0;
`else
    assign w_early     = 1'b0;
    assign w_early_res = 32'd0;
`endif
    // Multiply: accumulator low half holds the multiplier, shifted out one bit per cycle.
    assign w_msum = {1'b0, r_acc[63:32]} + {1'b0, r_acc[0] ? r_op : 32'd0};
    // Divide: {remainder, dividend/quotient} shifted left, restoring subtract each cycle.
    assign w_rem  = {r_acc[63:32], r_acc[31]};
    assign w_ge   = w_rem >= {1'b0, r_op};
    assign w_rsub = w_rem[31:0] - r_op;
    assign w_next = r_f3[2] ? {w_ge ? w_rsub : w_rem[31:0], r_acc[30:0], w_ge} : {w_msum, r_acc[31:1]};
    assign w_prod = r_negq ? -w_next : w_next;
    assign w_q    = r_negq ? -w_next[31:0] : w_next[31:0];
    assign w_r    = r_negr ? -w_next[63:32] : w_next[63:32];
    assign w_final = r_f3[2] ? (r_f3[1] ? w_r : w_q) : (r_f3[1:0] == 2'b00 ? w_prod[31:0] : w_prod[63:32]);
    assign mdStall = rst && ((r_state == IDLE && w_start) || r_state == BUSY);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_cnt         <= 5'd0;
            r_f3          <= 3'd0;
            r_op          <= 32'd0;
            r_acc         <= 64'd0;
            r_negq        <= 1'b0;
            r_negr        <= 1'b0;
            mdResult      <= 32'd0;
            mdResultValid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_start) begin
                    r_f3   <= exFunct3;
                    r_negq <= w_na ^ w_nb;
                    r_negr <= w_na;
                    r_op   <= w_div ? w_mb : w_ma;
                    r_acc  <= {32'd0, w_div ? w_ma : w_mb};
                    r_cnt  <= 5'd0;
                    if (w_dz || w_ovf || w_early) begin
                        r_state       <= DONE;
                        mdResult      <= (w_dz || w_ovf) ? w_fast_res : w_early_res;
                        mdResultValid <= 1'b1;
                    end else begin
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    r_acc <= w_next;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state       <= DONE;
                        mdResult      <= w_final;
                        mdResultValid <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    mdResultValid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed and random M-op checks of ex_muldiv_unit against an arithmetic reference.
module tb_ex_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  exAluOp = 3'd0;
    logic [2:0]  exFunct3 = 3'd0;
    logic [6:0]  exFunct7 = 7'd0;
    logic [31:0] exLHSOperand = 32'd0;
    logic [31:0] exRHSOperand = 32'd0;
    logic        mdStall;
    logic [31:0] mdResult;
    logic        mdResultValid;
    int n_vec = 0;
    int n_err = 0;

    ex_muldiv_unit dut (
        .clk(clk), .rst(rst), .exAluOp(exAluOp), .exFunct3(exFunct3), .exFunct7(exFunct7),
        .exLHSOperand(exLHSOperand), .exRHSOperand(exRHSOperand),
        .mdStall(mdStall), .mdResult(mdResult), .mdResultValid(mdResultValid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f3)
            3'd0: p = sa * sb;
            3'd1: p = (sa * sb) >>> 32;
            3'd2: p = (sa * ub) >>> 32;
            3'd3: p = $signed($unsigned(ua) * $unsigned(ub)) >>> 32;
            3'd4: p = (b == 0) ? -64'sd1 : sa / sb;
            3'd5: p = (b == 0) ? -64'sd1 : ua / ub;
            3'd6: p = (b == 0) ? sa : sa % sb;
            default: p = (b == 0) ? ua : ua % ub;
        endcase
        return p[31:0];
    endfunction

    function automatic int ref_stall(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint da, db;
        if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_EARLY_OUT_EN
        if (!f3[2] && (a == 0 || b == 0)) return 1;
        da = f3[0] ? longint'({32'd0, a}) : longint'($signed(a));
        db = f3[0] ? longint'({32'd0, b}) : longint'($signed(b));
        if (da < 0) da = -da;
        if (db < 0) db = -db;
        if (f3[2] && da < db) return 1;
`else
        da = 0;
        db = 0;
`endif
        return 33;
    endfunction

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] res;
        int st;
        bit seen;
        res = 32'd0;
        st = 0;
        seen = 1'b0;
        @(negedge clk);
        exAluOp = 3'b010;
        exFunct7 = 7'b0000001;
        exFunct3 = f3;
        exLHSOperand = a;
        exRHSOperand = b;
        for (int i = 0; i < 40 && !seen; i++) begin
            #1;
            if (mdResultValid) begin
                seen = 1'b1;
                res = mdResult;
                check("done_stall", {31'd0, mdStall}, 32'd0);
            end else begin
                st += int'(mdStall);
                @(negedge clk);
            end
        end
        exAluOp = 3'd0;
        exFunct7 = 7'd0;
        check("done_seen", {31'd0, seen}, 32'd1);
        check($sformatf("res f3=%0d %h,%h", f3, a, b), res, ref_md(f3, a, b));
        check($sformatf("stall f3=%0d %h,%h", f3, a, b), st, ref_stall(f3, a, b));
    endtask

    task automatic idle_check();
        @(negedge clk);
        #1;
        check("idle_valid", {31'd0, mdResultValid}, 32'd0);
        check("idle_stall", {31'd0, mdStall}, 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        exAluOp = 3'b010;
        exFunct7 = 7'b0000001;
        repeat (2) @(negedge clk);
        check("rst_stall", {31'd0, mdStall}, 32'd0);
        check("rst_valid", {31'd0, mdResultValid}, 32'd0);
        check("rst_result", mdResult, 32'd0);
        exAluOp = 3'd0;
        exFunct7 = 7'd0;
        rst = 1'b1;
        run_op(3'd0, 32'd7, -32'sd3);
        idle_check();
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2);
        run_op(3'd4, -32'sd7, 32'd2);
        run_op(3'd6, -32'sd7, 32'd2);
        run_op(3'd5, 32'd100, 32'd7);
        run_op(3'd7, 32'd100, 32'd7);
        run_op(3'd4, 32'd5, 32'd0);
        run_op(3'd7, 32'd5, 32'd0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd0, 32'd3, 32'd4);
        run_op(3'd0, 32'd5, 32'd6);
        idle_check();
        @(negedge clk);
        exAluOp = 3'b010;
        exFunct7 = 7'd0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("add_stall", {31'd0, mdStall}, 32'd0);
            @(negedge clk);
        end
        exAluOp = 3'd0;
        run_op(3'd0, 32'd0, 32'd9);
        run_op(3'd6, -32'sd3, 32'd10);
        run_op(3'd5, 32'd3, 32'd10);
        for (int i = 0; i < 60; i++) run_op(3'($urandom_range(0, 7)), pick(), pick());
        run_op(3'd0, 32'd11, 32'd13);
        @(negedge clk);
        exAluOp = 3'b010;
        exFunct7 = 7'b0000001;
        exFunct3 = 3'd0;
        exLHSOperand = 32'd7;
        exRHSOperand = 32'd9;
        repeat (11) @(posedge clk);
        #2;
        check("busy_stall", {31'd0, mdStall}, 32'd1);
        rst = 1'b0;
        #1;
        check("abort_stall", {31'd0, mdStall}, 32'd0);
        check("abort_valid", {31'd0, mdResultValid}, 32'd0);
        check("abort_result", mdResult, 32'd0);
        @(negedge clk);
        exAluOp = 3'd0;
        exFunct7 = 7'd0;
        #1;
        check("abort_hold", mdResult, 32'd0);
        rst = 1'b1;
        idle_check();
        run_op(3'd0, 32'd2, 32'd2);
        idle_check();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
